// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port: round-robin between two
// requesters, with an optional zero-fill of x1..x31 after reset.
module regfile_wb_arbiter #(
  parameter int XLEN           = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            init_busy
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic       GRANT_A  = 1'b0;
  localparam logic       GRANT_B  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [4:0]      clr_idx_q, clr_idx_d;
  logic            last_grant_q, last_grant_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            grant_a, grant_b;

  // Readies are gated by reset so nothing offered during reset is taken.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset && state_q == ST_RUN) begin
      if (a_valid && (!b_valid || last_grant_q == GRANT_B)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wdata_d   = rf_wdata_q;
    if (state_q == ST_CLEAR) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = clr_idx_q;
      rf_wdata_d = '0;
      clr_idx_d  = clr_idx_q + 5'd1;
      if (clr_idx_q == 5'd31) begin
        state_d = ST_RUN;
      end
    end else if (grant_a) begin
      last_grant_d = GRANT_A;
      // x0 writes complete the handshake but never reach the port.
      if (a_rd != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = a_rd;
        rf_wdata_d = a_data;
      end
    end else if (grant_b) begin
      last_grant_d = GRANT_B;
      if (b_rd != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = b_rd;
        rf_wdata_d = b_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_idx_q    <= 5'd1;
      last_grant_q <= GRANT_B;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= 5'd0;
      rf_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;
  assign init_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against
// a behavioural round-robin model; a second instance covers CLEAR_ON_RESET=0.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            a_valid, b_valid;
  logic [4:0]      a_rd, b_rd;
  logic [XLEN-1:0] a_data, b_data;

  logic            a_ready, b_ready, rf_we, init_busy;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

  logic            a_ready0, b_ready0, rf_we0, init_busy0;
  logic [4:0]      rf_rd0;
  logic [XLEN-1:0] rf_wdata0;

  int checks;
  int passed;

  regfile_wb_arbiter #(.XLEN(XLEN), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .init_busy(init_busy)
  );

  regfile_wb_arbiter #(.XLEN(XLEN), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready0), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready0), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we0), .rf_rd(rf_rd0), .rf_wdata(rf_wdata0), .init_busy(init_busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_rd = 5'd0; b_rd = 5'd0;
    a_data = '0; b_data = '0;
  endtask

  // Reset for one cycle then run through the 31-cycle zero-fill unchecked.
  task automatic reset_and_clear();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (31) step();
  endtask

  task automatic test_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd4; b_rd = 5'd6;
    a_data = 64'hAAAA; b_data = 64'hBBBB;
    reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0)
        $display("FAIL reset_ready cyc=%0d got a=%0b b=%0b exp 0/0", i, a_ready, b_ready);
      else passed++;
      step();
      checks++;
      if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 64'd0 || init_busy !== 1'b1)
        $display("FAIL reset_state got we=%0b rd=%0d wd=%0h busy=%0b exp 0/0/0/1",
                 rf_we, rf_rd, rf_wdata, init_busy);
      else passed++;
    end
    $display("test_reset done");
  endtask

  // Valids stay high throughout to show readies are held off during the fill.
  task automatic check_clear_sequence(input string tag);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      checks++;
      if (init_busy !== 1'b1 || a_ready !== 1'b0 || b_ready !== 1'b0)
        $display("FAIL %s_busy k=%0d got busy=%0b a=%0b b=%0b exp 1/0/0",
                 tag, k, init_busy, a_ready, b_ready);
      else passed++;
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== k[4:0] || rf_wdata !== 64'd0)
        $display("FAIL %s_write k=%0d got we=%0b rd=%0d wd=%0h exp 1/%0d/0",
                 tag, k, rf_we, rf_rd, rf_wdata, k);
      else passed++;
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (init_busy !== 1'b0)
      $display("FAIL %s_busy_fall got %0b exp 0", tag, init_busy);
    else passed++;
    step();
  endtask

  task automatic test_clear();
    reset = 1'b0;
    check_clear_sequence("clear");
    $display("test_clear done");
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h1234;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL single_a_ready got a=%0b b=%0b exp 1/0", a_ready, b_ready);
    else passed++;
    step();
    idle_inputs();
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 64'h1234)
      $display("FAIL single_a_write got we=%0b rd=%0d wd=%0h exp 1/5/1234", rf_we, rf_rd, rf_wdata);
    else passed++;
    step();
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 64'h1234)
      $display("FAIL idle_hold got we=%0b rd=%0d wd=%0h exp 0/5/1234", rf_we, rf_rd, rf_wdata);
    else passed++;
    $display("test_single_a done");
  endtask

  task automatic test_round_robin();
    logic exp_a;
    reset_and_clear();
    a_valid = 1'b1; b_valid = 1'b1;
    a_rd = 5'd10; b_rd = 5'd20; a_data = 64'hA0; b_data = 64'hB0;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if (a_ready !== exp_a || b_ready !== !exp_a)
        $display("FAIL rr_grant i=%0d got a=%0b b=%0b exp %0b/%0b", i, a_ready, b_ready, exp_a, !exp_a);
      else passed++;
      step();
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== (exp_a ? 5'd10 : 5'd20) || rf_wdata !== (exp_a ? 64'hA0 : 64'hB0))
        $display("FAIL rr_write i=%0d got we=%0b rd=%0d wd=%0h exp_a=%0b", i, rf_we, rf_rd, rf_wdata, exp_a);
      else passed++;
    end
    idle_inputs();
    step();
    $display("test_round_robin done");
  endtask

  // Last grant was B; an x0 write by B must still hand the next tie to A.
  task automatic test_rd_zero();
    b_valid = 1'b1; b_rd = 5'd0; b_data = 64'hFF;
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0)
      $display("FAIL rd0_ready got a=%0b b=%0b exp 0/1", a_ready, b_ready);
    else passed++;
    step();
    checks++;
    if (rf_we !== 1'b0)
      $display("FAIL rd0_we got %0b exp 0", rf_we);
    else passed++;
    b_rd = 5'd0; a_valid = 1'b1; a_rd = 5'd1; a_data = 64'h11;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0)
      $display("FAIL rd0_lastgrant got a=%0b b=%0b exp 1/0", a_ready, b_ready);
    else passed++;
    step();
    idle_inputs();
    step();
    $display("test_rd_zero done");
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (9) step();
    checks++;
    if (rf_rd !== 5'd9)
      $display("FAIL midclr_pos got rd=%0d exp 9", rf_rd);
    else passed++;
    reset = 1'b1;
    step();
    checks++;
    if (rf_we !== 1'b0 || init_busy !== 1'b1)
      $display("FAIL midclr_reset got we=%0b busy=%0b exp 0/1", rf_we, init_busy);
    else passed++;
    reset = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd7; b_rd = 5'd8;
    check_clear_sequence("midclr");
    $display("test_reset_mid_clear done");
  endtask

  task automatic test_random();
    logic            a_pend, b_pend, lg_b, ga, gb, exp_we;
    logic [4:0]      ar, br, exp_rd;
    logic [XLEN-1:0] ad, bd, exp_wd;
    int errs;
    reset_and_clear();
    a_pend = 1'b0; b_pend = 1'b0; lg_b = 1'b1;
    ar = '0; br = '0; ad = '0; bd = '0;
    exp_rd = 5'd31; exp_wd = '0;
    errs = 0;
    for (int n = 0; n < 300; n++) begin
      if (!a_pend && $urandom_range(0, 1) == 1) begin
        a_pend = 1'b1;
        ar = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ad = {$urandom, $urandom};
      end
      if (!b_pend && $urandom_range(0, 1) == 1) begin
        b_pend = 1'b1;
        br = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bd = {$urandom, $urandom};
      end
      a_valid = a_pend; a_rd = ar; a_data = ad;
      b_valid = b_pend; b_rd = br; b_data = bd;
      ga = a_pend && (!b_pend || lg_b);
      gb = b_pend && !ga;
      @(negedge clk);
      checks++;
      if (a_ready !== ga || b_ready !== gb) begin
        $display("FAIL rand_ready n=%0d got a=%0b b=%0b exp %0b/%0b", n, a_ready, b_ready, ga, gb);
        errs++;
      end else passed++;
      exp_we = 1'b0;
      if (ga) begin
        lg_b = 1'b0; a_pend = 1'b0;
        if (ar != 0) begin exp_we = 1'b1; exp_rd = ar; exp_wd = ad; end
      end else if (gb) begin
        lg_b = 1'b1; b_pend = 1'b0;
        if (br != 0) begin exp_we = 1'b1; exp_rd = br; exp_wd = bd; end
      end
      step();
      checks++;
      if (rf_we !== exp_we || rf_rd !== exp_rd || rf_wdata !== exp_wd) begin
        $display("FAIL rand_write n=%0d got we=%0b rd=%0d wd=%0h exp %0b/%0d/%0h",
                 n, rf_we, rf_rd, rf_wdata, exp_we, exp_rd, exp_wd);
        errs++;
      end else passed++;
    end
    idle_inputs();
    step();
    $display("test_random done errors=%0d", errs);
  endtask

  task automatic test_no_clear();
    idle_inputs();
    reset = 1'b1;
    step();
    checks++;
    if (init_busy0 !== 1'b0 || rf_we0 !== 1'b0)
      $display("FAIL noclr_reset got busy=%0b we=%0b exp 0/0", init_busy0, rf_we0);
    else passed++;
    reset = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'h33;
    @(negedge clk);
    checks++;
    if (a_ready0 !== 1'b1 || init_busy0 !== 1'b0)
      $display("FAIL noclr_ready got a=%0b busy=%0b exp 1/0", a_ready0, init_busy0);
    else passed++;
    step();
    idle_inputs();
    checks++;
    if (rf_we0 !== 1'b1 || rf_rd0 !== 5'd3 || rf_wdata0 !== 64'h33 || init_busy0 !== 1'b0)
      $display("FAIL noclr_write got we=%0b rd=%0d wd=%0h busy=%0b exp 1/3/33/0",
               rf_we0, rf_rd0, rf_wdata0, init_busy0);
    else passed++;
    $display("test_no_clear done");
  endtask

  initial begin
    checks = 0;
    passed = 0;
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_clear();
    test_single_a();
    test_round_robin();
    test_rd_zero();
    test_reset_mid_clear();
    test_random();
    test_no_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: XLEN, default 64, data width of write port and requesters.
REQ-002 Parameter: CLEAR_ON_RESET, default 1; 1 = zero-fill sequence after reset, 0 = go straight to RUN.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-006 a_ready  output  1  requester A write accepted this cycle.
REQ-007 a_rd  input  5  requester A destination register index.
REQ-008 a_data  input  XLEN  requester A write data.
REQ-009 b_valid  input  1  requester B (load/multi-cycle writeback) has a write pending.
REQ-010 b_ready  output  1  requester B write accepted this cycle.
REQ-011 b_rd  input  5  requester B destination register index.
REQ-012 b_data  input  XLEN  requester B write data.
REQ-013 rf_we  output  1  write enable to the register file write port, registered.
REQ-014 rf_rd  output  5  write address to the register file, registered.
REQ-015 rf_wdata  output  XLEN  write data to the register file, registered.
REQ-016 init_busy  output  1  high while the zero-fill sequence runs.

Function
REQ-017 FSM states: CLEAR, RUN; state held in a flop; init_busy = (state==CLEAR).
REQ-018 Handshake: transfer occurs when valid and ready are both high in the same cycle; requester holds valid, rd, data stable until its ready is high.
REQ-019 a_ready/b_ready are combinational from state, last_grant flop and the valids; never depend on rd/data.
REQ-020 In CLEAR: a_ready=b_ready=0 regardless of valids.
REQ-021 In CLEAR, each posedge registers rf_we=1, rf_rd=clr_idx, rf_wdata=0, then increments clr_idx (5-bit).
REQ-022 clr_idx starts at 1; edge that registers clr_idx=31 moves state to RUN; x0 never written by the sequence.
REQ-023 In RUN, at most one ready high per cycle; ready only asserted for a requester whose valid is high.
REQ-024 Arbitration in RUN: only one valid -> grant it; both valid -> grant the requester not equal to last_grant (round-robin).
REQ-025 last_grant updates only on a completed transfer, to the granted requester.
REQ-026 Latency: transfer in cycle N -> rf_we=1, rf_rd/rf_wdata = granted rd/data in cycle N+1; throughput one write per cycle.
REQ-027 No transfer in RUN -> next cycle rf_we=0; rf_rd/rf_wdata hold previous values.
REQ-028 Transfer with rd=0 is accepted (ready high, handshake completes, last_grant updates) but registers rf_we=0; x0 is never written.
REQ-029 Same rd from A and B in the same cycle: only the granted one is written that cycle; loser written in a later cycle, so final value follows grant order.
REQ-030 rf_* change only at posedge, stable across the register file's negedge write sample.

Reset
REQ-031 While reset is high at a posedge: rf_we=0, rf_rd=0, rf_wdata=0, clr_idx=1, last_grant=B, state=CLEAR if CLEAR_ON_RESET=1 else RUN.
REQ-032 Readies are 0 in any cycle where reset is high; transfers offered during reset are not accepted.
REQ-033 Reset mid-CLEAR or mid-RUN aborts the operation in progress; the zero-fill sequence restarts from clr_idx=1.
REQ-034 After reset release with CLEAR_ON_RESET=1: init_busy high exactly 31 cycles; first possible ready in cycle 32.

Verification
REQ-035 Reset, idle valids -> 31 consecutive cycles rf_we=1, rf_rd=1..31, rf_wdata=0; init_busy falls after the 31st; a_ready/b_ready stay 0 throughout.
REQ-036 RUN, only a_valid, a_rd=5, a_data=0x1234 -> a_ready=1 same cycle; next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234.
REQ-037 RUN after reset, a_valid and b_valid held high 4 cycles -> grants A,B,A,B; rf_rd follows a_rd,b_rd,a_rd,b_rd one cycle later.
REQ-038 RUN, b_valid, b_rd=0, b_data=0xFF -> b_ready=1; next cycle rf_we=0.
REQ-039 Reset pulsed when clr_idx=10 -> rf_we=0 during reset; sequence restarts at rf_rd=1; init_busy high 31 more cycles.
REQ-040 CLEAR_ON_RESET=0, reset then a_valid, a_rd=3 first cycle -> a_ready=1 immediately, init_busy never high.
